cfg_stream_loader: RTL and testbench

Synthesizable, parametrised successor to the per-design simulation config wrappers. It accepts bitstream words over a valid/ready stream and serialises them into a fabric's scan-chain config port (`cfg_e`/`cfg_i`), `CFG_WIDTH` bits per cycle. It counts configured bits against a runtime total, stalls cleanly on input underflow and supports abort and reconfiguration. It holds the user-design reset asserted until configuration has settled. It sits between a bitstream source (memory reader, host link) and the `top` fabric instance.

---
 rtl/cfg_stream_loader_pkg.sv | 22 ++
 rtl/cfg_word_serializer.sv | 62 ++++++
 rtl/cfg_stream_loader.sv | 150 +++++++++++++++
 tb/tb_cfg_stream_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cfg_stream_loader_pkg.sv
// Shared types and parameter legality check for the config stream loader.
package cfg_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FLUSH,
        ST_SETTLE,
        ST_STABLE
    } state_t;

    // A word must split into whole chunks, counters need room, settle is never zero.
    function automatic bit cfg_params_ok(input int unsigned cfg_width,
                                         input int unsigned word_width,
                                         input int unsigned cnt_width,
                                         input int unsigned settle_cycles);
        return (cfg_width >= 1) && (word_width >= cfg_width) &&
               ((word_width % cfg_width) == 0) && (cnt_width >= 2) &&
               (settle_cycles >= 1);
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// One-word buffer that accepts bitstream words and emits them chunk by chunk, LSB first.
module cfg_word_serializer
    import cfg_stream_loader_pkg::*;
#(
    parameter int unsigned CFG_WIDTH  = 1,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_fetch_en,
    input  logic                  i_flush,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    input  logic [WORD_WIDTH-1:0] i_word_data,
    output logic                  o_cfg_e,
    output logic [CFG_WIDTH-1:0]  o_cfg_i,
    output logic [CNT_WIDTH-1:0]  o_rem_bits
);

    localparam int unsigned CHUNKS = WORD_WIDTH / CFG_WIDTH;
    localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [WORD_WIDTH-1:0] r_buf;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_full;
    logic                  w_last_chunk;
    logic                  w_accept;

    assign w_last_chunk = (r_idx == IDX_W'(CHUNKS - 1));
    // Refill while the last chunk shifts so a continuous stream has no bubbles.
    assign o_word_ready = i_fetch_en && (!r_full || w_last_chunk);
    assign w_accept     = o_word_ready && i_word_valid && !i_flush;

    assign o_cfg_e    = r_full;
    assign o_cfg_i    = r_full ? r_buf[r_idx*CFG_WIDTH +: CFG_WIDTH] : '0;
    assign o_rem_bits = r_full ? CNT_WIDTH'((CHUNKS - 32'(r_idx)) * CFG_WIDTH) : '0;

    // Buffer load, chunk advance and discard on flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (i_flush) begin
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_buf  <= i_word_data;
            r_idx  <= '0;
            r_full <= 1'b1;
        end else if (r_full) begin
            if (w_last_chunk) begin
                r_idx  <= '0;
                r_full <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_stream_loader.sv
// Streams bitstream words into a fabric scan-chain config port and sequences the user reset.
module cfg_stream_loader
    import cfg_stream_loader_pkg::*;
#(
    parameter int unsigned CFG_WIDTH     = 1,
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  total_bits,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  cfg_e,
    output logic [CFG_WIDTH-1:0]  cfg_i,
    output logic                  app_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  bits_shifted
);

    localparam int unsigned CNT_W1 = CNT_WIDTH + 1;
    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    if (!cfg_params_ok(CFG_WIDTH, WORD_WIDTH, CNT_WIDTH, SETTLE_CYCLES)) begin : g_bad_params
        $error("cfg_stream_loader: illegal parameter combination");
    end

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_total;
    logic [CNT_WIDTH-1:0] r_bits;
    logic [SET_W-1:0]     r_settle;
    logic                 r_app_reset;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_cfg_e;
    logic [CNT_WIDTH-1:0] w_rem_bits;
    logic [CNT_WIDTH:0]   w_sum_chunk;
    logic [CNT_WIDTH:0]   w_sum_buf;
    logic                 w_in_busy;
    logic                 w_abort_act;
    logic                 w_last_shift;
    logic                 w_final_in_buf;
    logic                 w_fetch_en;
    logic                 w_flush;

    assign w_sum_chunk = {1'b0, r_bits} + CNT_W1'(CFG_WIDTH);
    assign w_sum_buf   = {1'b0, r_bits} + {1'b0, w_rem_bits};

    assign w_in_busy      = (r_state == ST_SHIFT) || (r_state == ST_FLUSH) || (r_state == ST_SETTLE);
    assign w_abort_act    = abort && w_in_busy;
    assign w_last_shift   = (r_state == ST_SHIFT) && w_cfg_e && (w_sum_chunk >= {1'b0, r_total});
    // Once the buffered word reaches the total, no further word may be taken.
    assign w_final_in_buf = (w_sum_buf >= {1'b0, r_total});
    assign w_fetch_en     = (r_state == ST_SHIFT) && !w_final_in_buf;
    assign w_flush        = w_abort_act || w_last_shift;

    cfg_word_serializer #(
        .CFG_WIDTH  (CFG_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ser (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_fetch_en   (w_fetch_en),
        .i_flush      (w_flush),
        .i_word_valid (word_valid),
        .o_word_ready (word_ready),
        .i_word_data  (word_data),
        .o_cfg_e      (w_cfg_e),
        .o_cfg_i      (cfg_i),
        .o_rem_bits   (w_rem_bits)
    );

    assign cfg_e        = w_cfg_e;
    assign app_reset    = r_app_reset;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign bits_shifted = r_bits;

    // Load sequencing FSM with bit counter, settle timer and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_total     <= '0;
            r_bits      <= '0;
            r_settle    <= '0;
            r_app_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_abort_act) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE, ST_STABLE: begin
                        if (start) begin
                            if (total_bits == '0) begin
                                r_err <= 1'b1;
                            end else begin
                                r_state     <= ST_SHIFT;
                                r_total     <= total_bits;
                                r_bits      <= '0;
                                r_app_reset <= 1'b1;
                                r_busy      <= 1'b1;
                                r_done      <= 1'b0;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (w_last_shift) begin
                            r_bits  <= r_total;
                            r_state <= ST_FLUSH;
                        end else if (w_cfg_e) begin
                            r_bits <= r_bits + CNT_WIDTH'(CFG_WIDTH);
                        end
                    end
                    ST_FLUSH: begin
                        r_settle <= '0;
                        r_state  <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (r_settle == SET_W'(SETTLE_CYCLES - 1)) begin
                            r_state     <= ST_STABLE;
                            r_app_reset <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_settle <= r_settle + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: one CFG_WIDTH=1 and one CFG_WIDTH=4 instance.
module tb_cfg_stream_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        sel;
    logic        start;
    logic        abort;
    logic [31:0] total_bits;
    logic        word_valid;
    logic [15:0] word_data;

    logic        d1_start, d1_abort, d1_valid, d1_ready, d1_cfg_e, d1_app, d1_busy, d1_done, d1_err;
    logic [0:0]  d1_cfg_i;
    logic [31:0] d1_bits;
    logic        d4_start, d4_abort, d4_valid, d4_ready, d4_cfg_e, d4_app, d4_busy, d4_done, d4_err;
    logic [3:0]  d4_cfg_i;
    logic [31:0] d4_bits;

    logic        o_ready, o_cfg_e, o_app, o_busy, o_done, o_err;
    logic [3:0]  o_cfg_i;
    logic [31:0] o_bits;

    assign d1_start = start && !sel;
    assign d1_abort = abort && !sel;
    assign d1_valid = word_valid && !sel;
    assign d4_start = start && sel;
    assign d4_abort = abort && sel;
    assign d4_valid = word_valid && sel;

    assign o_ready = sel ? d4_ready : d1_ready;
    assign o_cfg_e = sel ? d4_cfg_e : d1_cfg_e;
    assign o_cfg_i = sel ? d4_cfg_i : {3'b000, d1_cfg_i};
    assign o_app   = sel ? d4_app   : d1_app;
    assign o_busy  = sel ? d4_busy  : d1_busy;
    assign o_done  = sel ? d4_done  : d1_done;
    assign o_err   = sel ? d4_err   : d1_err;
    assign o_bits  = sel ? d4_bits  : d1_bits;

    cfg_stream_loader #(.CFG_WIDTH(1), .WORD_WIDTH(16), .CNT_WIDTH(32), .SETTLE_CYCLES(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(d1_start), .abort(d1_abort), .total_bits(total_bits),
        .word_valid(d1_valid), .word_ready(d1_ready), .word_data(word_data), .cfg_e(d1_cfg_e),
        .cfg_i(d1_cfg_i), .app_reset(d1_app), .busy(d1_busy), .done(d1_done), .err(d1_err),
        .bits_shifted(d1_bits)
    );

    cfg_stream_loader #(.CFG_WIDTH(4), .WORD_WIDTH(16), .CNT_WIDTH(32), .SETTLE_CYCLES(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(d4_start), .abort(d4_abort), .total_bits(total_bits),
        .word_valid(d4_valid), .word_ready(d4_ready), .word_data(word_data), .cfg_e(d4_cfg_e),
        .cfg_i(d4_cfg_i), .app_reset(d4_app), .busy(d4_busy), .done(d4_done), .err(d4_err),
        .bits_shifted(d4_bits)
    );

    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] words [2];
    logic [3:0]  seq [$];
    int          hs_cnt, cfg_cnt, first_cfg, last_cfg, done_cyc, gap_bits;
    logic        ready0, st_app, st_done;
    logic [31:0] st_bits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_seq(input int unsigned stride);
        logic [31:0] v = '0;
        foreach (seq[i]) v |= 32'(seq[i]) << (i * stride);
        return v;
    endfunction

    // Pulse start, then feed words[0..1] one cycle at a time until done, timeout or abort.
    task automatic run_load(input logic [31:0] tot, input int holdoff, input int abort_after);
        int widx = 0;
        int hold = 0;
        int cyc  = 0;
        bit fin  = 0;
        seq.delete();
        hs_cnt = 0; cfg_cnt = 0; first_cfg = -1; last_cfg = -1; done_cyc = -1; gap_bits = -1;
        start = 1'b1; total_bits = tot; word_valid = 1'b0;
        @(posedge clk); #1;
        start   = 1'b0;
        st_app  = o_app;
        st_done = o_done;
        st_bits = o_bits;
        ready0  = o_ready;
        while (!fin) begin
            if (o_done) begin
                done_cyc = cyc;
                fin = 1;
            end else if (cyc >= 400) begin
                chk("load_timeout_done", 32'(o_done), 32'd1);
                fin = 1;
            end else begin
                word_valid = (widx < 2) && (hold == 0);
                word_data  = (widx < 2) ? words[widx] : 16'h0000;
                abort      = (abort_after > 0) && (cfg_cnt == abort_after);
                if (o_cfg_e) begin
                    seq.push_back(o_cfg_i);
                    cfg_cnt++;
                    if (first_cfg < 0) first_cfg = cyc;
                    last_cfg = cyc;
                end else if (cfg_cnt > 0 && o_ready && gap_bits < 0) begin
                    gap_bits = int'(o_bits);
                end
                if (o_ready && word_valid) begin
                    hs_cnt++;
                    widx++;
                    if (widx == 1) hold = holdoff;
                end else if (hold > 0) begin
                    hold--;
                end
                @(posedge clk); #1;
                cyc++;
                if (abort) begin
                    abort = 1'b0;
                    word_valid = 1'b0;
                    fin = 1;
                end
            end
        end
        word_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; sel = 1'b0; start = 1'b0; abort = 1'b0;
        word_valid = 1'b1; word_data = 16'hFFFF; total_bits = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",     32'(o_ready), 32'd0);
        chk("rst_cfg_e",     32'(o_cfg_e), 32'd0);
        chk("rst_cfg_i",     32'(o_cfg_i), 32'd0);
        chk("rst_app_reset", 32'(o_app),   32'd1);
        chk("rst_busy",      32'(o_busy),  32'd0);
        chk("rst_done",      32'(o_done),  32'd0);
        chk("rst_err",       32'(o_err),   32'd0);
        chk("rst_bits",      o_bits,       32'd0);
        reset_n = 1'b1; word_valid = 1'b0;
        @(posedge clk); #1;

        // Continuous stream, total 20.
        words[0] = 16'hA5C3; words[1] = 16'h000F;
        run_load(32'd20, 0, 0);
        chk("cont_ready_c1",   32'(ready0),   32'd1);
        chk("cont_first_cfg",  32'(first_cfg), 32'd1);
        chk("cont_cfg_count",  32'(cfg_cnt),  32'd20);
        chk("cont_gaps",       32'(last_cfg - first_cfg + 1 - cfg_cnt), 32'd0);
        chk("cont_seq",        pack_seq(1),   32'h000F_A5C3);
        chk("cont_handshakes", 32'(hs_cnt),   32'd2);
        chk("cont_done_lat",   32'(done_cyc - last_cfg), 32'd4);
        chk("cont_bits",       o_bits,        32'd20);
        chk("cont_app_reset",  32'(o_app),    32'd0);

        // Reconfiguration from STABLE with a 3-cycle underflow.
        run_load(32'd20, 18, 0);
        chk("reconf_app_reset", 32'(st_app),  32'd1);
        chk("reconf_done_low",  32'(st_done), 32'd0);
        chk("uf_cfg_count",     32'(cfg_cnt), 32'd20);
        chk("uf_gaps",          32'(last_cfg - first_cfg + 1 - cfg_cnt), 32'd3);
        chk("uf_gap_bits",      32'(gap_bits), 32'd16);
        chk("uf_seq",           pack_seq(1),  32'h000F_A5C3);
        chk("uf_done_lat",      32'(done_cyc - last_cfg), 32'd4);

        // Abort after 7 shifts.
        run_load(32'd20, 0, 7);
        chk("abort_err",       32'(o_err),   32'd1);
        chk("abort_cfg_e",     32'(o_cfg_e), 32'd0);
        chk("abort_busy",      32'(o_busy),  32'd0);
        chk("abort_app_reset", 32'(o_app),   32'd1);
        chk("abort_ready",     32'(o_ready), 32'd0);
        chk("abort_bits",      o_bits,       32'd7);
        @(posedge clk); #1;
        chk("abort_err_pulse", 32'(o_err),   32'd0);

        // Zero-length start stays in IDLE.
        start = 1'b1; total_bits = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_err",   32'(o_err),   32'd1);
        chk("zero_busy",  32'(o_busy),  32'd0);
        chk("zero_ready", 32'(o_ready), 32'd0);
        chk("zero_app",   32'(o_app),   32'd1);
        @(posedge clk); #1;
        chk("zero_err_pulse", 32'(o_err), 32'd0);

        // Restart after abort.
        run_load(32'd20, 0, 0);
        chk("restart_bits0", st_bits,      32'd0);
        chk("restart_seq",   pack_seq(1),  32'h000F_A5C3);
        chk("restart_count", 32'(cfg_cnt), 32'd20);

        // Wide partial: CFG_WIDTH 4, total 18.
        sel = 1'b1;
        words[0] = 16'h4321; words[1] = 16'h0765;
        run_load(32'd18, 0, 0);
        chk("wide_cfg_count",  32'(cfg_cnt), 32'd5);
        chk("wide_seq",        pack_seq(4),  32'h0005_4321);
        chk("wide_bits",       o_bits,       32'd18);
        chk("wide_handshakes", 32'(hs_cnt),  32'd2);
        chk("wide_done_lat",   32'(done_cyc - last_cfg), 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
